// File: rtl/max7219_pkg.sv
// Shared constants, main-FSM states and word packing for the MAX7219 frame sequencer.
package max7219_pkg;

  localparam logic [3:0] REG_NOOP      = 4'h0;
  localparam logic [3:0] REG_DIGIT0    = 4'h1;
  localparam logic [3:0] REG_DECODE    = 4'h9;
  localparam logic [3:0] REG_INTENSITY = 4'hA;
  localparam logic [3:0] REG_SCANLIM   = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
  localparam logic [3:0] REG_DISPTEST  = 4'hF;

  localparam int unsigned NUM_ROWS  = 8;
  localparam logic [2:0]  INIT_LAST = 3'd4;
  localparam logic [2:0]  ROW_LAST  = 3'd7;

  typedef enum logic [2:0] {
    ST_INIT_ISSUE,
    ST_INIT_WAIT,
    ST_IDLE,
    ST_INT_ISSUE,
    ST_INT_WAIT,
    ST_ROW_ISSUE,
    ST_ROW_WAIT,
    ST_FRAME_END
  } state_e;

  function automatic logic [15:0] make_word(input logic [3:0] addr, input logic [7:0] val);
    return {4'h0, addr, val};
  endfunction

endpackage

// File: rtl/max7219_frame_buf.sv
// 8x8 frame buffer, one write port and one async read port.
// With MAX7219_DBUF_EN: front/back banks, writes to back, reads from front, swap flips them.
module max7219_frame_buf
  import max7219_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_data,
`ifdef MAX7219_DBUF_EN
  input  logic       swap,
`endif
  input  logic [2:0] rd_row,
  output logic [7:0] rd_data
);

`ifdef MAX7219_DBUF_EN
  logic [7:0] mem_q [2][NUM_ROWS];
  logic [7:0] mem_d [2][NUM_ROWS];
  logic       front_q, front_d;

  always_comb begin
    mem_d   = mem_q;
    front_d = front_q ^ swap;
    if (wr_en) mem_d[~front_q][wr_row] = wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      front_q <= 1'b0;
      for (int unsigned b = 0; b < 2; b++)
        for (int unsigned i = 0; i < NUM_ROWS; i++)
          mem_q[b][i] <= '0;
    end else begin
      front_q <= front_d;
      mem_q   <= mem_d;
    end
  end

  assign rd_data = mem_q[front_q][rd_row];
`else
  logic [7:0] mem_q [NUM_ROWS];
  logic [7:0] mem_d [NUM_ROWS];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_row] = wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_ROWS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_row];
`endif

endmodule

// File: rtl/max7219_frame_ctrl.sv
// MAX7219 sequencer: power-up register sequence, then 8 digit-register writes per frame.
// Optional double-buffered frame store with swap_req when MAX7219_DBUF_EN is defined.
module max7219_frame_ctrl
  import max7219_pkg::*;
#(
  parameter logic [2:0] SCAN_LIMIT   = 3'd7,
  parameter logic [7:0] DECODE_MODE  = 8'h00,
  parameter logic [3:0] INTENSITY0   = 4'h8,
  parameter logic       AUTO_REFRESH = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  intensity_in,
  input  logic        wr_en,
  input  logic [2:0]  wr_row,
  input  logic [7:0]  wr_data,
`ifdef MAX7219_DBUF_EN
  input  logic        swap_req,
`endif
  input  logic        drv_rdy,
  output logic        drv_en,
  output logic [15:0] drv_data,
  output logic        init_done,
  output logic        busy,
  output logic        frame_done
);

  state_e      state_q, state_d;
  logic        hs_lo_q, hs_lo_d;
  logic [2:0]  init_idx_q, init_idx_d;
  logic [2:0]  row_q, row_d;
  logic [3:0]  cur_int_q, cur_int_d;
  logic [3:0]  pend_int_q, pend_int_d;
  logic        drv_en_q, drv_en_d;
  logic [15:0] drv_data_q, drv_data_d;
  logic        init_done_q, init_done_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic        in_wait, word_done, go;
  logic [7:0]  rd_data;
  logic        swap_do;

  function automatic logic [15:0] init_word(input logic [2:0] idx);
    case (idx)
      3'd0:    return make_word(REG_DISPTEST, 8'h00);
      3'd1:    return make_word(REG_SCANLIM, {5'b0, SCAN_LIMIT});
      3'd2:    return make_word(REG_DECODE, DECODE_MODE);
      3'd3:    return make_word(REG_INTENSITY, {4'h0, INTENSITY0});
      default: return make_word(REG_SHUTDOWN, 8'h01);
    endcase
  endfunction

`ifdef MAX7219_DBUF_EN
  logic swap_pend_q, swap_pend_d;

  // Swap only between frames so a frame is never built from two banks.
  always_comb begin
    swap_do     = swap_pend_q && (state_q == ST_IDLE || state_q == ST_FRAME_END);
    swap_pend_d = (swap_pend_q && !swap_do) || swap_req;
  end
`else
  assign swap_do = 1'b0;
`endif

  max7219_frame_buf u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_row  (wr_row),
    .wr_data (wr_data),
`ifdef MAX7219_DBUF_EN
    .swap    (swap_do),
`endif
    .rd_row  (row_q),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d      = state_q;
    hs_lo_d      = hs_lo_q;
    init_idx_d   = init_idx_q;
    row_d        = row_q;
    cur_int_d    = cur_int_q;
    pend_int_d   = pend_int_q;
    drv_en_d     = 1'b0;
    drv_data_d   = drv_data_q;
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;

    // Every WAIT state is split into "seen RDY low" then "RDY back high".
    in_wait   = (state_q == ST_INIT_WAIT) || (state_q == ST_INT_WAIT) ||
                (state_q == ST_ROW_WAIT);
    if (in_wait && !drv_rdy) hs_lo_d = 1'b1;
    word_done = in_wait && hs_lo_q && drv_rdy;
    go        = AUTO_REFRESH | start;

    unique case (state_q)
      ST_INIT_ISSUE: if (drv_rdy) begin
        drv_en_d   = 1'b1;
        drv_data_d = init_word(init_idx_q);
        hs_lo_d    = 1'b0;
        state_d    = ST_INIT_WAIT;
      end
      ST_INIT_WAIT: if (word_done) begin
        if (init_idx_q == INIT_LAST) begin
          init_done_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          init_idx_d = init_idx_q + 3'd1;
          state_d    = ST_INIT_ISSUE;
        end
      end
      ST_IDLE: if (go) begin
        pend_int_d = intensity_in;
        row_d      = '0;
        state_d    = (intensity_in != cur_int_q) ? ST_INT_ISSUE : ST_ROW_ISSUE;
      end
      ST_INT_ISSUE: if (drv_rdy) begin
        drv_en_d   = 1'b1;
        drv_data_d = make_word(REG_INTENSITY, {4'h0, pend_int_q});
        hs_lo_d    = 1'b0;
        state_d    = ST_INT_WAIT;
      end
      ST_INT_WAIT: if (word_done) begin
        cur_int_d = pend_int_q;
        state_d   = ST_ROW_ISSUE;
      end
      ST_ROW_ISSUE: if (drv_rdy) begin
        drv_en_d   = 1'b1;
        drv_data_d = make_word(REG_DIGIT0 + {1'b0, row_q}, rd_data);
        hs_lo_d    = 1'b0;
        state_d    = ST_ROW_WAIT;
      end
      ST_ROW_WAIT: if (word_done) begin
        if (row_q == ROW_LAST) begin
          frame_done_d = 1'b1;
          state_d      = ST_FRAME_END;
        end else begin
          row_d   = row_q + 3'd1;
          state_d = ST_ROW_ISSUE;
        end
      end
      ST_FRAME_END: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT_ISSUE;
      hs_lo_q      <= 1'b0;
      init_idx_q   <= '0;
      row_q        <= '0;
      cur_int_q    <= INTENSITY0;
      pend_int_q   <= INTENSITY0;
      drv_en_q     <= 1'b0;
      drv_data_q   <= '0;
      init_done_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef MAX7219_DBUF_EN
      swap_pend_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      hs_lo_q      <= hs_lo_d;
      init_idx_q   <= init_idx_d;
      row_q        <= row_d;
      cur_int_q    <= cur_int_d;
      pend_int_q   <= pend_int_d;
      drv_en_q     <= drv_en_d;
      drv_data_q   <= drv_data_d;
      init_done_q  <= init_done_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
`ifdef MAX7219_DBUF_EN
      swap_pend_q  <= swap_pend_d;
`endif
    end
  end

  assign drv_en     = drv_en_q;
  assign drv_data   = drv_data_q;
  assign init_done  = init_done_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
